// File: rtl/dcache_uncache_resp_pkg.sv
// Shared encodings for the uncached data-access responder: FSM states, bus type codes, access sizes.
package dcache_uncache_resp_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_WR_REQ  = 3'd5;

  localparam logic [2:0] BUS_TYPE_BYTE = 3'b000;
  localparam logic [2:0] BUS_TYPE_HALF = 3'b001;
  localparam logic [2:0] BUS_TYPE_WORD = 3'b010;
  localparam logic [2:0] BUS_TYPE_LINE = 3'b100;

  localparam int DATA_SIZE_BYTE = 8;
  localparam int DATA_SIZE_HALF = 16;
  localparam int DATA_SIZE_WORD = 32;

  // The request size code maps directly onto the low bits of the bus type.
  function automatic logic [2:0] bus_type(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/dcache_uncache_resp.sv
// Uncached load/store responder: accepts one EX request, resolves it in LOOKUP, runs a single-word bus access.
// Load latency addr_ok->data_ok is 4 cycles minimum; store data_ok coincides with wr_rdy. One request outstanding.
module dcache_uncache_resp
  import dcache_uncache_resp_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [2:0] RD_TYPE_WORD = 3'b010
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid,
  input  logic                    op,
  input  logic [1:0]              size,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    addr_ok,
  input  logic                    uncache_en,
  input  logic                    tlb_excp_cancel_req,
  input  logic                    sc_cancel_req,
  input  logic                    flush,
  output logic                    data_ok,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_req,
  output logic [2:0]              rd_type,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [DATA_WIDTH-1:0]   ret_data,
  output logic                    wr_req,
  output logic [2:0]              wr_type,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH/8-1:0] wr_wstrb,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_rdy,
  output logic                    busy
);

  logic [2:0]              r_state;
  logic [2:0]              w_next;
  logic                    r_op;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_drop;
  logic                    w_cancel;
  logic                    w_ret_end;
  logic                    w_drop_now;

  assign w_cancel   = flush | tlb_excp_cancel_req | sc_cancel_req;
  assign w_ret_end  = ret_valid & ret_last;
  // A flush arriving in the final return cycle still discards the data.
  assign w_drop_now = r_drop | flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (valid) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_cancel || !uncache_en) w_next = S_IDLE;
        else                         w_next = r_op ? S_WR_REQ : S_RD_REQ;
      end
      S_RD_REQ: begin
        if (rd_rdy)     w_next = S_RD_WAIT;
        else if (flush) w_next = S_IDLE;
      end
      S_RD_WAIT: if (w_ret_end) w_next = w_drop_now ? S_IDLE : S_RESP;
      S_RESP:    w_next = S_IDLE;
      S_WR_REQ:  if (wr_rdy || flush) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (addr_ok) begin
        r_op    <= op;
        r_size  <= size;
        r_addr  <= addr;
        r_wstrb <= wstrb;
        r_wdata <= wdata;
      end
      // Handshake and flush in the same RD_REQ cycle: the beat is owed, so drain it.
      if (r_state == S_RD_REQ)
        r_drop <= rd_rdy & flush;
      else if (r_state == S_RD_WAIT)
        r_drop <= w_ret_end ? 1'b0 : w_drop_now;
      else
        r_drop <= 1'b0;
      if (r_state == S_RD_WAIT && w_ret_end && !w_drop_now)
        r_rdata <= ret_data;
    end
  end

  assign addr_ok  = valid && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  assign rd_req   = (r_state == S_RD_REQ);
  assign rd_type  = bus_type(r_size);
  assign rd_addr  = (bus_type(r_size) == RD_TYPE_WORD) ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : r_addr;

  assign wr_req   = (r_state == S_WR_REQ);
  assign wr_type  = bus_type(r_size);
  assign wr_addr  = r_addr;
  assign wr_wstrb = r_wstrb;
  assign wr_data  = r_wdata;

  assign data_ok  = ((r_state == S_RESP) || (wr_req && wr_rdy)) && !flush;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_dcache_uncache_resp.sv
module tb_dcache_uncache_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid, op;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok;
  logic        uncache_en, tlb_excp_cancel_req, sc_cancel_req, flush;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy, ret_valid, ret_last;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [2:0]  wr_type;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_uncache_resp dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .uncache_en(uncache_en),
    .tlb_excp_cancel_req(tlb_excp_cancel_req), .sc_cancel_req(sc_cancel_req),
    .flush(flush), .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy), .busy(busy)
  );

  typedef struct {
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        uc, tlb, sc;
    int          d, r;
    logic [31:0] ret;
    int          req_cyc;
    logic [31:0] e_addr;
    logic [2:0]  e_type;
    int          e_dok;
    int          e_lat;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; op = 0; size = 0; addr = 0; wstrb = 0; wdata = 0;
    uncache_en = 0; tlb_excp_cancel_req = 0; sc_cancel_req = 0; flush = 0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rcnt = 0, wcnt = 0, ndok = 0, lat = -1, bad = 0;
    bit hs = 0, retdone = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    tick();
    valid = 1; op = v.op; size = v.size; addr = v.addr; wstrb = v.wstrb; wdata = v.wdata;
    @(negedge clk);
    chk({tag, "_addr_ok"}, {31'd0, addr_ok}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      valid = 0;
      uncache_en          = (k == 1) ? v.uc  : 1'b0;
      tlb_excp_cancel_req = (k == 1) ? v.tlb : 1'b0;
      sc_cancel_req       = (k == 1) ? v.sc  : 1'b0;
      rd_rdy = 0; wr_rdy = 0; ret_valid = 0; ret_last = 0;
      if (rd_req) begin rd_rdy = (rcnt == v.d); rcnt++; end
      if (wr_req) begin wr_rdy = (rcnt == v.d); rcnt++; end
      if (hs && !retdone) begin
        ret_valid = (wcnt == v.r); ret_last = ret_valid; ret_data = v.ret; wcnt++;
        if (ret_valid) retdone = 1;
      end
      @(negedge clk);
      if (rd_req && (rd_addr !== v.e_addr || rd_type !== v.e_type)) bad++;
      if (wr_req && (wr_addr !== v.e_addr || wr_type !== v.e_type ||
                     wr_wstrb !== v.wstrb || wr_data !== v.wdata)) bad++;
      if (rd_req && rd_rdy) hs = 1;
      if (data_ok) begin ndok++; lat = k; end
      if (k == 2) chk({tag, "_busy_after_lookup"}, {31'd0, busy}, (v.req_cyc > 0) ? 32'd1 : 32'd0);
    end
    chk({tag, "_req_cycles"}, rcnt, v.req_cyc);
    chk({tag, "_bus_fields"}, bad, 0);
    chk({tag, "_data_ok_count"}, ndok, v.e_dok);
    if (v.e_dok > 0) chk({tag, "_latency"}, lat, v.e_lat);
    chk({tag, "_rdata"}, rdata, v.e_rdata);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndok;
    vecs[0] = '{1'b0, 2'd2, 32'h1FD0_0010, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1, 32'hDEAD_BEEF,
                2, 32'h1FD0_0010, 3'b010, 1, 6, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 2'd0, 32'h1FD0_0003, 4'b1000, 32'hAA00_0000, 1'b1, 1'b0, 1'b0, 3, 0, 32'h0,
                4, 32'h1FD0_0003, 3'b000, 1, 5, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 2'd2, 32'h1FD0_0013, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h1234_5678,
                1, 32'h1FD0_0010, 3'b010, 1, 4, 32'h1234_5678};
    vecs[3] = '{1'b0, 2'd1, 32'h1FD0_0012, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 3, 32'hCAFE_0000,
                1, 32'h1FD0_0012, 3'b001, 1, 7, 32'hCAFE_0000};
    vecs[4] = '{1'b0, 2'd2, 32'h1FD0_0040, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 32'h1111_1111,
                0, 32'h0, 3'b000, 0, 0, 32'hCAFE_0000};
    vecs[5] = '{1'b1, 2'd2, 32'h1FD0_0044, 4'hF, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0,
                0, 32'h0, 3'b000, 0, 0, 32'hCAFE_0000};
    vecs[6] = '{1'b0, 2'd2, 32'h1FD0_0048, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h3333_3333,
                0, 32'h0, 3'b000, 0, 0, 32'hCAFE_0000};
    vecs[7] = '{1'b1, 2'd2, 32'h1FD0_0020, 4'hF, 32'h0123_4567, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0,
                1, 32'h1FD0_0020, 3'b010, 1, 2, 32'hCAFE_0000};

    idle_inputs();
    resetn = 0;
    #23;
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Flush in RD_WAIT: drain five cycles, then a fresh load must complete.
    tick(); valid = 1; op = 0; size = 2; addr = 32'h1FD0_0050;
    @(negedge clk); chk("drain_accept", {31'd0, addr_ok}, 32'd1);
    tick(); valid = 0; uncache_en = 1; @(negedge clk);
    tick(); uncache_en = 0; rd_rdy = 1; @(negedge clk);
    chk("drain_rd_req", {31'd0, rd_req}, 32'd1);
    tick(); rd_rdy = 0; flush = 1; @(negedge clk);
    chk("drain_busy_flush", {31'd0, busy}, 32'd1);
    ndok = 0;
    if (data_ok) ndok++;
    addr = 32'h1FD0_0054;
    for (int i = 1; i <= 5; i++) begin
      tick(); flush = 0; valid = 1;
      ret_valid = (i == 5); ret_last = (i == 5); ret_data = 32'h9999_9999;
      @(negedge clk);
      if (data_ok) ndok++;
      chk($sformatf("drain_addr_ok_c%0d", i), {31'd0, addr_ok}, 32'd0);
      chk($sformatf("drain_busy_c%0d", i), {31'd0, busy}, 32'd1);
    end
    tick(); ret_valid = 0; ret_last = 0; @(negedge clk);
    if (data_ok) ndok++;
    chk("drain_no_data_ok", ndok, 0);
    chk("drain_rdata_kept", rdata, 32'hCAFE_0000);
    chk("drain_release_addr_ok", {31'd0, addr_ok}, 32'd1);
    tick(); valid = 0; uncache_en = 1; @(negedge clk);
    tick(); uncache_en = 0; rd_rdy = 1; @(negedge clk);
    chk("next_rd_addr", rd_addr, 32'h1FD0_0054);
    tick(); rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h5A5A_5A5A; @(negedge clk);
    tick(); ret_valid = 0; ret_last = 0; @(negedge clk);
    chk("next_data_ok", {31'd0, data_ok}, 32'd1);
    chk("next_rdata", rdata, 32'h5A5A_5A5A);
    tick(); @(negedge clk);
    chk("next_data_ok_pulse", {31'd0, data_ok}, 32'd0);
    chk("next_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset while a read request is pending on the bus.
    tick(); valid = 1; op = 0; size = 2; addr = 32'h1FD0_0060; @(negedge clk);
    tick(); valid = 0; uncache_en = 1; @(negedge clk);
    tick(); uncache_en = 0; @(negedge clk);
    chk("arst_rd_req_before", {31'd0, rd_req}, 32'd1);
    #2 resetn = 0;
    #1;
    chk("arst_rd_req_drop", {31'd0, rd_req}, 32'd0);
    chk("arst_busy_drop", {31'd0, busy}, 32'd0);
    chk("arst_rdata_clear", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("arst_post_busy", {31'd0, busy}, 32'd0);
    chk("arst_post_rd_req", {31'd0, rd_req}, 32'd0);
    chk("arst_post_rdata", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
